id_char_tx: RTL and testbench
=============================

// Module: id_char_tx
// PURPOSE
//   Identifier character-stream generator: emits one ASCII char per accepted beat.
//   Sequence: let_cnt lowercase letters, then dig_cnt digits, then TERM_CHAR.
//   Producer end of the char stream consumed by the identifier-recognition FSM.
//   Drives that FSM in benches and self-test paths with legal and illegal identifiers.
// PARAMETERS
//   CNT_W      4      width of let_cnt/dig_cnt; max 2**CNT_W-1 chars per field
//   TERM_CHAR  8'h20  terminator emitted after the last digit (ASCII space)
// PORTS
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous, active-low reset
//   start       in   1      request pulse; sampled only in IDLE
//   let_cnt     in   CNT_W  number of letters, latched on accepted start
//   dig_cnt     in   CNT_W  number of digits, latched on accepted start
//   let_base    in   8      first letter, latched on accepted start
//   dig_base    in   8      first digit, latched on accepted start
//   char        out  8      current character (registered)
//   char_valid  out  1      char is valid
//   char_ready  in   1      consumer accepts char this cycle
//   busy        out  1      high from accepted start until done
//   done        out  1      1-cycle pulse after TERM_CHAR is accepted
//   err         out  1      1-cycle pulse when start is rejected
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE; char=8'h00; char_valid/busy/done/err=0.
//   States: IDLE -> LET -> DIG -> TERM -> IDLE; all outputs registered.
//   IDLE: start=1 and let_cnt!=0 -> latch inputs; busy=1; enter LET with char=base letter, char_valid=1.
//     First char is visible the cycle after start (latency 1).
//   IDLE: start=1 and let_cnt==0 -> err=1 for one cycle, stay IDLE.
//     An identifier must begin with a letter.
//   start outside IDLE is ignored: no err, no latch.
//   Handshake: beat = char_valid & char_ready. char/char_valid hold stable while valid&!ready.
//     char_valid deasserts only in IDLE.
//   LET: each beat advances the letter. After let_cnt beats:
//     -> DIG (char=digit base) if dig_cnt!=0, else -> TERM (char=TERM_CHAR).
//   DIG: each beat advances the digit; after dig_cnt beats -> TERM.
//   TERM: on beat -> IDLE; char_valid=0, busy=0, done=1 for one cycle; char keeps TERM_CHAR.
//   Clamping at latch: let_base outside 'a'..'z' becomes 'a'; dig_base outside '0'..'9' becomes '0'.
//   Wrap-around: 'z'+1 -> 'a', '9'+1 -> '0'. Field length is not limited by the alphabet.
//   Next start is accepted in the same cycle done=1, since state is already IDLE.
//   Remaining-count registers are CNT_W bits and count down to 1; no overflow possible.
//   Reset mid-stream aborts immediately: no done, outputs return to reset values.
// STRUCTURE
//   Shared package id_pkg:
//     state enum (IDLE/LET/DIG/TERM), ASCII constants CH_A=8'h61, CH_Z=8'h7A, CH_0=8'h30, CH_9=8'h39.
//     Shared with the recognizer FSM.
//   Sub-module id_char_step: combinational next-char. In: cur char, class (letter/digit). Out: incremented char with wrap.
//   Remaining FSM, counters and output registers live in id_char_tx.
// TESTING
//   1. let=4, dig=4, bases 'a','0', ready=1:
//      -> 61,62,63,64,30,31,32,33,20 on consecutive cycles; done 1 cycle after 20; busy low then.
//   2. let=3, dig=0, base 'x':
//      -> 78,79,7A,20; wrap check with let=3, base 'y' -> 79,7A,61,20.
//   3. Backpressure: ready toggles 1,0,0,1 on case 1 -> each char held while ready=0; no skips, no repeats.
//   4. let=0 start -> err pulse 1 cycle, char_valid stays 0, busy 0.
//      start while busy -> ignored; in-flight stream unchanged.
//   5. rst_n low during DIG -> outputs 0 immediately; after release a new start runs cleanly from first letter.
//   6. let_base=8'h41 ('A'), dig_base=8'h39, let=1, dig=2 -> 61,39,30,20 (clamp + digit wrap).

Source files
------------

// File: rtl/id_pkg.sv
// Shared identifier definitions: FSM state encoding, character classes and ASCII bounds.
// No logic or latency of its own; used by the char-stream generator and the recognizer FSM.
// Backpressure: not applicable.
// Contents: id_state_t, id_class_t, CH_A/CH_Z/CH_0/CH_9, clamp_let(), clamp_dig().
package id_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LET  = 2'd1,
      DIG  = 2'd2,
      TERM = 2'd3
   } id_state_t;

   typedef enum logic {
      CLS_LET = 1'b0,
      CLS_DIG = 1'b1
   } id_class_t;

   localparam logic [7:0] CH_A = 8'h61;
   localparam logic [7:0] CH_Z = 8'h7A;
   localparam logic [7:0] CH_0 = 8'h30;
   localparam logic [7:0] CH_9 = 8'h39;

   // Out-of-alphabet bases fall back to the first character of the class.
   function automatic logic [7:0] clamp_let(input logic [7:0] c);
      return ((c >= CH_A) && (c <= CH_Z)) ? c : CH_A;
   endfunction

   function automatic logic [7:0] clamp_dig(input logic [7:0] c);
      return ((c >= CH_0) && (c <= CH_9)) ? c : CH_0;
   endfunction

endpackage

// File: rtl/id_char_step.sv
// Next character within a class (letter or digit), wrapping at the end of the alphabet.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to use the result.
// Ports: cur (current char), cls (letter/digit class), nxt (successor char).
module id_char_step
   import id_pkg::*;
(
   input  logic [7:0] cur,
   input  id_class_t  cls,
   output logic [7:0] nxt
);

   always_comb begin
      nxt = cur + 8'd1;
      case (cls)
         CLS_LET: if (cur == CH_Z) nxt = CH_A;
         CLS_DIG: if (cur == CH_9) nxt = CH_0;
         default: nxt = cur + 8'd1;
      endcase
   end

endmodule

// File: rtl/id_char_tx.sv
// Identifier char-stream generator: let_cnt letters, dig_cnt digits, then TERM_CHAR.
// Latency: first char valid one cycle after an accepted start; one char per beat thereafter.
// Backpressure: char/char_valid hold while char_ready is low; start is only sampled in IDLE.
// Ports: clk, rst_n; start/let_cnt/dig_cnt/let_base/dig_base request; char/char_valid/char_ready
//        stream; busy, done (pulse after terminator), err (pulse on rejected start).
module id_char_tx
   import id_pkg::*;
#(
   parameter int         CNT_W     = 4,
   parameter logic [7:0] TERM_CHAR = 8'h20
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] let_cnt,
   input  logic [CNT_W-1:0] dig_cnt,
   input  logic [7:0]       let_base,
   input  logic [7:0]       dig_base,
   output logic [7:0]       char,
   output logic             char_valid,
   input  logic             char_ready,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   id_state_t        state;
   logic [CNT_W-1:0] rem;        // chars left in the current field, counts down to 1
   logic [CNT_W-1:0] dig_len;    // digit field length, loaded into rem on LET->DIG
   logic [7:0]       dig_first;  // clamped digit base, emitted on LET->DIG
   logic [7:0]       char_nxt;
   id_class_t        step_cls;
   logic             beat;

   assign beat     = char_valid & char_ready;
   assign step_cls = (state == DIG) ? CLS_DIG : CLS_LET;

   id_char_step u_step (
      .cur (char),
      .cls (step_cls),
      .nxt (char_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         rem        <= '0;
         dig_len    <= '0;
         dig_first  <= CH_0;
         char       <= 8'h00;
         char_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (let_cnt != '0) begin
                     rem        <= let_cnt;
                     dig_len    <= dig_cnt;
                     dig_first  <= clamp_dig(dig_base);
                     char       <= clamp_let(let_base);
                     char_valid <= 1'b1;
                     busy       <= 1'b1;
                     state      <= LET;
                  end else begin
                     // An identifier must begin with a letter.
                     err <= 1'b1;
                  end
               end
            end
            LET: begin
               if (beat) begin
                  if (rem == CNT_ONE) begin
                     if (dig_len != '0) begin
                        char  <= dig_first;
                        rem   <= dig_len;
                        state <= DIG;
                     end else begin
                        char  <= TERM_CHAR;
                        state <= TERM;
                     end
                  end else begin
                     char <= char_nxt;
                     rem  <= rem - CNT_ONE;
                  end
               end
            end
            DIG: begin
               if (beat) begin
                  if (rem == CNT_ONE) begin
                     char  <= TERM_CHAR;
                     state <= TERM;
                  end else begin
                     char <= char_nxt;
                     rem  <= rem - CNT_ONE;
                  end
               end
            end
            TERM: begin
               // char keeps TERM_CHAR after the stream ends.
               if (beat) begin
                  char_valid <= 1'b0;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_id_char_tx.sv
// Bench for id_char_tx: directed vector table, hand-written corner sequences and random
// streams checked against an arithmetic reference of the identifier character sequence.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_id_char_tx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [3:0] let_cnt;
   logic [3:0] dig_cnt;
   logic [7:0] let_base;
   logic [7:0] dig_base;
   logic [7:0] char;
   logic       char_valid;
   logic       char_ready;
   logic       busy;
   logic       done;
   logic       err;

   int nvec = 0;
   int nerr = 0;

   logic [7:0] exp_q [0:63];
   int         exp_n;

   typedef struct {
      int         l;
      int         d;
      logic [7:0] lb;
      logic [7:0] db;
      int         n;
      logic [79:0] seq;   // expected chars, first char in the top byte
      int         mode;   // 0: always ready, 1: ready 1,0,0,1 pattern, 2: random
   } vec_t;

   vec_t tv [5];

   always #5 clk = ~clk;

   id_char_tx #(.CNT_W(4), .TERM_CHAR(8'h20)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .let_cnt    (let_cnt),
      .dig_cnt    (dig_cnt),
      .let_base   (let_base),
      .dig_base   (dig_base),
      .char       (char),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      nvec++;
      if (act !== want) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, want, $time);
      end
   endtask

   // Reference: letters walk the 26-letter alphabet, digits the 10 digits, then a space.
   task automatic model(input int l, input int d, input logic [7:0] lb, input logic [7:0] db);
      int lo;
      int dof;
      lo  = (lb >= 8'h61 && lb <= 8'h7A) ? int'(lb) - 97 : 0;
      dof = (db >= 8'h30 && db <= 8'h39) ? int'(db) - 48 : 0;
      exp_n = 0;
      for (int i = 0; i < l; i++) begin
         exp_q[exp_n] = 8'(97 + (lo + i) % 26);
         exp_n++;
      end
      for (int i = 0; i < d; i++) begin
         exp_q[exp_n] = 8'(48 + (dof + i) % 10);
         exp_n++;
      end
      exp_q[exp_n] = 8'h20;
      exp_n++;
   endtask

   // Streams one identifier and checks every observed char against exp_q.
   // chain=1: start is raised on the current falling edge (the one where done was seen).
   // inject=1: a second start is pulsed mid-stream and must be ignored.
   task automatic run_stream(input int l, input int d, input logic [7:0] lb, input logic [7:0] db,
                             input int mode, input bit chain, input bit inject);
      int  idx;
      int  cyc;
      bit  rdy;
      idx = 0;
      cyc = 0;
      if (!chain) @(negedge clk);
      let_cnt    = 4'(l);
      dig_cnt    = 4'(d);
      let_base   = lb;
      dig_base   = db;
      start      = 1'b1;
      char_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      chk("done_low_after_start", {31'd0, done}, 32'd0);
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      while (idx < exp_n && cyc < 400) begin
         if (cyc > 0) @(negedge clk);
         chk("char_valid", {31'd0, char_valid}, 32'd1);
         chk("char", {24'd0, char}, {24'd0, exp_q[idx]});
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         if (inject && cyc == 2) begin
            start    = 1'b1;
            let_cnt  = 4'd7;
            let_base = 8'h71;
            dig_base = 8'h35;
         end
         if (inject && cyc == 3) begin
            start = 1'b0;
            chk("err_on_busy_start", {31'd0, err}, 32'd0);
         end
         char_ready = rdy;
         if (rdy) idx++;
         cyc++;
      end
      if (idx < exp_n) begin
         nvec++;
         nerr++;
         $display("FAIL stream_timeout: got %0d beats, expected %0d", idx, exp_n);
      end
      start = 1'b0;
      @(negedge clk);
      char_ready = 1'b0;
      chk("done_pulse", {31'd0, done}, 32'd1);
      chk("valid_end", {31'd0, char_valid}, 32'd0);
      chk("busy_end", {31'd0, busy}, 32'd0);
      chk("char_end", {24'd0, char}, 32'h20);
   endtask

   initial begin
      tv[0] = '{4, 4, 8'h61, 8'h30, 9, 80'h61626364303132332000, 0};
      tv[1] = '{3, 0, 8'h78, 8'h30, 4, 80'h78797A20000000000000, 0};
      tv[2] = '{3, 0, 8'h79, 8'h30, 4, 80'h797A6120000000000000, 0};
      tv[3] = '{1, 2, 8'h41, 8'h39, 4, 80'h61393020000000000000, 0};
      tv[4] = '{4, 4, 8'h61, 8'h30, 9, 80'h61626364303132332000, 1};

      rst_n      = 1'b0;
      start      = 1'b0;
      let_cnt    = '0;
      dig_cnt    = '0;
      let_base   = '0;
      dig_base   = '0;
      char_ready = 1'b0;
      #3;
      chk("rst_char", {24'd0, char}, 32'd0);
      chk("rst_valid", {31'd0, char_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done_err", {30'd0, done, err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vector table.
      for (int i = 0; i < 5; i++) begin
         exp_n = tv[i].n;
         for (int k = 0; k < tv[i].n; k++) exp_q[k] = tv[i].seq[79 - 8*k -: 8];
         run_stream(tv[i].l, tv[i].d, tv[i].lb, tv[i].db, tv[i].mode, 1'b0, 1'b0);
      end

      // Rejected start: no letters.
      @(negedge clk);
      let_cnt = 4'd0;
      dig_cnt = 4'd3;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("err_pulse", {31'd0, err}, 32'd1);
      chk("err_valid", {31'd0, char_valid}, 32'd0);
      chk("err_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk("err_one_cycle", {31'd0, err}, 32'd0);
      chk("err_valid_later", {31'd0, char_valid}, 32'd0);

      // Start while busy is ignored.
      model(3, 3, 8'h63, 8'h35);
      run_stream(3, 3, 8'h63, 8'h35, 0, 1'b0, 1'b1);

      // Back-to-back: next start on the cycle done is high.
      model(2, 1, 8'h7A, 8'h39);
      run_stream(2, 1, 8'h7A, 8'h39, 0, 1'b1, 1'b0);

      // Reset during the digit field.
      @(negedge clk);
      let_cnt    = 4'd3;
      dig_cnt    = 4'd3;
      let_base   = 8'h61;
      dig_base   = 8'h30;
      start      = 1'b1;
      char_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("pre_reset_dig", {24'd0, char}, 32'h31);
      rst_n = 1'b0;
      #1;
      chk("midrst_char", {24'd0, char}, 32'd0);
      chk("midrst_valid", {31'd0, char_valid}, 32'd0);
      chk("midrst_busy_done", {30'd0, busy, done}, 32'd0);
      char_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model(2, 1, 8'h6D, 8'h37);
      run_stream(2, 1, 8'h6D, 8'h37, 0, 1'b0, 1'b0);

      // Random streams with random backpressure.
      for (int r = 0; r < 25; r++) begin
         int         l;
         int         d;
         logic [7:0] lb;
         logic [7:0] db;
         l  = $urandom_range(1, 15);
         d  = $urandom_range(0, 15);
         lb = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(97, 122)) : 8'($urandom_range(0, 255));
         db = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(48, 57)) : 8'($urandom_range(0, 255));
         model(l, d, lb, db);
         run_stream(l, d, lb, db, 2, 1'b0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
